// File: rtl/data_ram_resp_pkg.sv
// Shared types and constants for the data RAM with a request/response handshake.
package data_ram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_LATENCY     = 2;
  localparam int DEFAULT_DEPTH_WORDS = 1024;

  localparam int LANE_BITS = 8;
  localparam int NUM_LANES = 4;

  // Big-endian lanes: byte offset 0 lives in lane 3 (sel[3], bits [31:24]).
  localparam int LANE_OFFSET0 = 3;
  localparam int LANE_OFFSET1 = 2;
  localparam int LANE_OFFSET2 = 1;
  localparam int LANE_OFFSET3 = 0;

  function automatic int lane_of_offset(input int offset);
    return NUM_LANES - 1 - offset;
  endfunction

endpackage

// File: rtl/data_ram_resp_byte_lane_ram.sv
// Single-port word array with per-byte write enables and a registered read port.
// A write returns the merged post-write word on the read port.
module byte_lane_ram
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS
) (
  input  logic                           clk,
  input  logic                           en,
  input  logic [3:0]                     we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (we[i]) begin
          mem[addr][i*LANE_BITS +: LANE_BITS] <= wdata[i*LANE_BITS +: LANE_BITS];
          rdata[i*LANE_BITS +: LANE_BITS]     <= wdata[i*LANE_BITS +: LANE_BITS];
        end else begin
          rdata[i*LANE_BITS +: LANE_BITS]     <= mem[addr][i*LANE_BITS +: LANE_BITS];
        end
      end
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// Handshake shell around byte_lane_ram: accepts one request in IDLE, waits
// LATENCY cycles, then presents a single-cycle response with the word or an error.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int LATENCY     = DEFAULT_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int          AW          = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [29:0] word_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic        err_q;

  logic        accept;
  logic        enter_resp;
  logic        in_range;
  logic        ram_en;
  logic [29:0] cur_word;
  logic [3:0]  cur_sel;
  logic [31:0] cur_wdata;
  logic [31:0] ram_rdata;
  logic [1:0]  unused_addr_lsb;

  assign unused_addr_lsb = addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept    = 1'b1;
          state_nxt = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt == 3'd1) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY=0 the commit happens on the accepting edge, so the RAM is fed
  // straight from the inputs while idle and from the latched request otherwise.
  assign cur_word   = (state == IDLE) ? addr[31:2] : word_q;
  assign cur_sel    = (state == IDLE) ? sel        : sel_q;
  assign cur_wdata  = (state == IDLE) ? wdata      : wdata_q;
  assign enter_resp = (state != RESP) && (state_nxt == RESP);
  assign in_range   = cur_word < DEPTH_LIMIT;
  assign ram_en     = enter_resp && in_range && rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 3'd0;
      word_q  <= 30'd0;
      sel_q   <= 4'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= 3'(LATENCY);
        word_q  <= addr[31:2];
        sel_q   <= sel;
        wdata_q <= wdata;
      end else if (state == WAIT) begin
        cnt <= cnt - 3'd1;
      end
      err_q <= enter_resp && !in_range;
    end
  end

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (cur_sel),
    .addr (cur_word[AW-1:0]),
    .wdata(cur_wdata),
    .rdata(ram_rdata)
  );

  assign addr_ok = (state == IDLE);
  assign data_ok = (state == RESP);
  assign err     = err_q;
  assign rdata   = (data_ok && !err_q) ? ram_rdata : 32'd0;

endmodule
